// File: rtl/generic_bus_mem_responder_if.sv
// Generic memory bus: initiator drives request, responder
// answers with rdata and busy.
interface generic_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  byen;
  logic        ren;
  logic        wen;
  logic        busy;

  modport generic_bus (
    input  addr, wdata, ren, wen, byen,
    output rdata, busy
  );

  modport cpu (
    output addr, wdata, ren, wen, byen,
    input  rdata, busy
  );
endinterface

// File: rtl/generic_bus_mem_responder.sv
// Word-addressed SRAM responder for generic_bus_if with
// byte-enable writes and fixed per-access wait states.
module generic_bus_mem_responder #(
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1,
  parameter logic [31:0] ERR_DATA      = 32'hBAD1_BAD1
) (
  input  logic                      CLK,
  input  logic                      RST,
  generic_bus_if.generic_bus        bus_if,
  output logic                      err,
  output logic [31:0]               access_count
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int unsigned MAXL =
    (READ_LATENCY > WRITE_LATENCY) ?
    READ_LATENCY : WRITE_LATENCY;
  localparam int CW = $clog2(MAXL + 1);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    IDLE, WAIT, RESP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic [3:0]      byen_q;
  logic            rd_q, rerr_q;
  logic            req, inr, rd_now, err_now;
  logic            enter_resp;
  logic [CW-1:0]   lat_m1;
  logic [31:0]     a_sel;
  logic [32:0]     off;
  logic [AW-1:0]   idx;
  logic [31:0]     mem [DEPTH_WORDS];

  assign req   = bus_if.ren | bus_if.wen;
  assign a_sel = (state_q == IDLE) ? bus_if.addr : addr_q;

  // 33-bit offset: addresses below BASE wrap high, so
  // a single compare covers both bounds.
  assign off = {1'b0, a_sel} - {1'b0, BASE_ADDR};
  assign inr = off < SPAN;
  assign idx = AW'(off >> 2);

  assign rd_now  = (state_q == IDLE) ? bus_if.ren : rd_q;
  assign err_now = (state_q == IDLE) ?
    ((bus_if.ren & bus_if.wen) | ~inr) : rerr_q;
  assign lat_m1  = bus_if.ren ?
    CW'(READ_LATENCY - 1) : CW'(WRITE_LATENCY - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_if.busy = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus_if.busy = req;
        if (req) begin
          cnt_d   = lat_m1;
          state_d = (lat_m1 == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        bus_if.busy = 1'b1;
        cnt_d       = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp =
    (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err          <= 1'b0;
      access_count <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      byen_q       <= '0;
      rd_q         <= 1'b0;
      rerr_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err     <= enter_resp & err_now;
      if (state_q == IDLE && req) begin
        addr_q  <= bus_if.addr;
        wdata_q <= bus_if.wdata;
        byen_q  <= bus_if.byen;
        rd_q    <= bus_if.ren;
        rerr_q  <= err_now;
      end
      if (enter_resp && rd_now)
        rdata_q <= inr ? mem[idx] : ERR_DATA;
      if (state_q == RESP)
        access_count <= access_count + 32'd1;
    end
  end

  // Writes commit on the edge leaving RESP.
  always_ff @(posedge CLK) begin
    if (!RST && state_q == RESP && !rd_q && inr) begin
      for (int i = 0; i < 4; i++)
        if (byen_q[i])
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end

  assign bus_if.rdata = rdata_q;
endmodule

// File: tb/tb_generic_bus_mem_responder.sv
// Scoreboard bench for generic_bus_mem_responder.
// Two instances: write latency 1 and write latency 3.
module tb_generic_bus_mem_responder;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_a, rst_b;
  logic err_a, err_b;
  logic [31:0] cnt_a, cnt_b;

  generic_bus_if bus_a();
  generic_bus_if bus_b();

  generic_bus_mem_responder #(
    .READ_LATENCY(2), .WRITE_LATENCY(1)
  ) u_a (
    .CLK(CLK), .RST(rst_a), .bus_if(bus_a),
    .err(err_a), .access_count(cnt_a)
  );

  generic_bus_mem_responder #(
    .READ_LATENCY(2), .WRITE_LATENCY(3)
  ) u_b (
    .CLK(CLK), .RST(rst_b), .bus_if(bus_b),
    .err(err_b), .access_count(cnt_b)
  );

  typedef struct {
    logic [31:0] rd;
    logic        e;
    logic        chk;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int errors = 0;
  int checks = 0;
  int nacc_a = 0;

  task automatic check(string name,
                       logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!rst_a) begin
      if ((bus_a.ren | bus_a.wen) && !bus_a.busy) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_completion");
        end else begin
          e = qa.pop_front();
          if (e.chk) check("a_rdata", bus_a.rdata, e.rd);
          check("a_err", 32'(err_a), 32'(e.e));
        end
      end else begin
        check("a_err_idle", 32'(err_a), 32'd0);
      end
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (!rst_b) begin
      if ((bus_b.ren | bus_b.wen) && !bus_b.busy) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_completion");
        end else begin
          e = qb.pop_front();
          if (e.chk) check("b_rdata", bus_b.rdata, e.rd);
          check("b_err", 32'(err_b), 32'(e.e));
        end
      end
    end
  end

  task automatic drive(int sel, logic r, logic w,
                       logic [31:0] a, logic [31:0] d,
                       logic [3:0] be);
    if (sel == 0) begin
      bus_a.ren = r; bus_a.wen = w; bus_a.addr = a;
      bus_a.wdata = d; bus_a.byen = be;
    end else begin
      bus_b.ren = r; bus_b.wen = w; bus_b.addr = a;
      bus_b.wdata = d; bus_b.byen = be;
    end
  endtask

  function automatic logic busy_of(int sel);
    return (sel == 0) ? bus_a.busy : bus_b.busy;
  endfunction

  task automatic access(int sel, logic r, logic w,
                        logic [31:0] a, logic [31:0] d,
                        logic [3:0] be,
                        logic [31:0] exp_rd,
                        logic exp_e, logic chk,
                        int exp_busy);
    exp_t e;
    int nb;
    bit done;
    e = '{exp_rd, exp_e, chk};
    if (sel == 0) begin
      qa.push_back(e);
      nacc_a++;
    end else begin
      qb.push_back(e);
    end
    @(posedge CLK); #1;
    drive(sel, r, w, a, d, be);
    nb = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (busy_of(sel)) nb++;
      else done = 1;
    end
    check("busy_cycles", 32'(nb), 32'(exp_busy));
    @(posedge CLK); #1;
    drive(sel, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k, c1, c2, nc;
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge CLK);
    check("rst_rdata", bus_a.rdata, 32'h0);
    check("rst_err", 32'(err_a), 32'h0);
    check("rst_count", cnt_a, 32'h0);
    check("rst_busy", 32'(bus_a.busy), 32'h0);

    // basic write then read
    access(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF,
           32'h0, 0, 0, 1);
    access(0, 1, 0, 32'h10, 32'h0, 4'h0,
           32'hDEAD_BEEF, 0, 1, 2);
    @(negedge CLK);
    check("count_t1", cnt_a, 32'd2);

    // byte enables
    access(0, 0, 1, 32'h20, 32'h1122_3344, 4'hF,
           32'h0, 0, 0, 1);
    access(0, 0, 1, 32'h20, 32'hAABB_CCDD, 4'h5,
           32'h0, 0, 0, 1);
    access(0, 1, 0, 32'h20, 32'h0, 4'h0,
           32'h11BB_33DD, 0, 1, 2);

    // range boundary and aliasing
    access(0, 0, 1, 32'h0, 32'hA0A0_0000, 4'hF,
           32'h0, 0, 0, 1);
    access(0, 0, 1, 32'hFFC, 32'h0FFC_0FFC, 4'hF,
           32'h0, 0, 0, 1);
    access(0, 1, 0, 32'h1000, 32'h0, 4'h0,
           32'hBAD1_BAD1, 1, 1, 2);
    access(0, 0, 1, 32'h1000, 32'h1234_5678, 4'hF,
           32'hBAD1_BAD1, 1, 1, 1);
    access(0, 1, 0, 32'hFFC, 32'h0, 4'h0,
           32'h0FFC_0FFC, 0, 1, 2);
    access(0, 1, 0, 32'h0, 32'h0, 4'h0,
           32'hA0A0_0000, 0, 1, 2);

    // ren and wen together
    access(0, 0, 1, 32'h30, 32'h5, 4'hF,
           32'h0, 0, 0, 1);
    access(0, 1, 1, 32'h30, 32'hFFFF_FFFF, 4'hF,
           32'h5, 1, 1, 2);
    access(0, 1, 0, 32'h30, 32'h0, 4'h0,
           32'h5, 0, 1, 2);

    // held read, address changed mid-wait
    access(0, 0, 1, 32'h4, 32'h4444_0004, 4'hF,
           32'h0, 0, 0, 1);
    qa.push_back('{32'hA0A0_0000, 1'b0, 1'b1});
    qa.push_back('{32'h4444_0004, 1'b0, 1'b1});
    nacc_a += 2;
    @(posedge CLK); #1;
    drive(0, 1, 0, 32'h0, 32'h0, 4'h0);
    @(posedge CLK); #1;
    bus_a.addr = 32'h4;
    k = 1;
    c1 = -1;
    c2 = -1;
    nc = 0;
    for (int i = 0; i < 20 && nc < 2; i++) begin
      @(negedge CLK);
      if (!bus_a.busy) begin
        if (nc == 0) c1 = k;
        else c2 = k;
        nc++;
      end
      k++;
    end
    check("held_first", 32'(c1), 32'd2);
    check("held_gap", 32'(c2 - c1), 32'd3);
    @(posedge CLK); #1;
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge CLK);
    check("count_a_total", cnt_a, 32'(nacc_a));

    // reset mid-write on latency-3 instance
    access(1, 0, 1, 32'h40, 32'h11, 4'hF,
           32'h0, 0, 0, 3);
    access(1, 1, 0, 32'h40, 32'h0, 4'h0,
           32'h11, 0, 1, 2);
    @(posedge CLK); #1;
    drive(1, 0, 1, 32'h40, 32'h77, 4'hF);
    @(negedge CLK);
    check("abort_busy0", 32'(bus_b.busy), 32'h1);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("abort_busy1", 32'(bus_b.busy), 32'h1);
    @(posedge CLK); #1;
    rst_b = 1'b1;
    @(negedge CLK);
    check("abort_busy2", 32'(bus_b.busy), 32'h1);
    @(posedge CLK); #1;
    rst_b = 1'b0;
    drive(1, 0, 0, 32'h0, 32'h0, 4'h0);
    @(negedge CLK);
    check("abort_count", cnt_b, 32'h0);
    check("abort_rdata", bus_b.rdata, 32'h0);
    check("abort_err", 32'(err_b), 32'h0);
    access(1, 1, 0, 32'h40, 32'h0, 4'h0,
           32'h11, 0, 1, 2);
    @(negedge CLK);
    check("abort_count_after", cnt_b, 32'd1);

    repeat (2) @(posedge CLK);
    check("qa_drained", 32'(qa.size()), 32'h0);
    check("qb_drained", 32'(qb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
